// File: rtl/aud_dsp_player.sv
// Playback engine: steps through an SRAM address window once per DAC frame,
// with normal/fast/slow-hold/slow-linear modes in either direction.
module aud_dsp_player #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned SPEED_W = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    input  logic [1:0]          i_mode,
    input  logic                i_reverse,
    input  logic [SPEED_W-1:0]  i_speed,
    input  logic                i_daclrck,
    input  logic [DATA_W-1:0]   i_sram_data,
    input  logic [ADDR_W-1:0]   i_start_addr,
    input  logic [ADDR_W-1:0]   i_stop_addr,
    output logic [DATA_W-1:0]   o_dac_data,
    output logic [ADDR_W-1:0]   o_sram_addr,
    output logic                o_fin,
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int unsigned IW = DATA_W + SPEED_W + 2;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [SPEED_W-1:0]        k_q, k_d;
    logic signed [DATA_W-1:0]  prev_q, prev_d;
    logic [DATA_W-1:0]         dac_q, dac_d;
    logic                      fin_q, fin_d;
    logic                      lrck_q;
    logic [1:0]                mode_q;

    logic                      tick;
    logic [SPEED_W:0]          n_val;
    logic [SPEED_W-1:0]        k_eff;
    logic [SPEED_W:0]          k_inc;
    logic                      do_step;
    logic [ADDR_W:0]           step_amt;
    logic [ADDR_W:0]           fwd_nxt;
    logic [ADDR_W:0]           rev_nxt;
    logic                      out_of_win;
    logic [ADDR_W-1:0]         nxt_addr;
    logic signed [IW-1:0]      w_n, w_k, num, quo;
    logic [DATA_W-1:0]         sample_val;

    assign tick    = lrck_q & ~i_daclrck;
    assign n_val   = {1'b0, i_speed} + (SPEED_W+1)'(1);
    // A mode change restarts the slow-mode phase counter
    assign k_eff   = (i_mode != mode_q) ? '0 : k_q;
    assign k_inc   = {1'b0, k_eff} + (SPEED_W+1)'(1);
    assign do_step = ~i_mode[1] | (k_inc == n_val);

    assign step_amt = (i_mode == 2'b01) ? (ADDR_W+1)'(n_val) : (ADDR_W+1)'(1);
    assign fwd_nxt  = {1'b0, addr_q} + step_amt;
    assign rev_nxt  = {1'b0, addr_q} - step_amt;
    // Extra MSB catches both overflow past the top and underflow below zero
    assign out_of_win = i_reverse ? (rev_nxt[ADDR_W] | (rev_nxt[ADDR_W-1:0] < i_start_addr))
                                  : (fwd_nxt > {1'b0, i_stop_addr});
    assign nxt_addr = i_reverse ? rev_nxt[ADDR_W-1:0] : fwd_nxt[ADDR_W-1:0];

    assign w_n = $signed(IW'(n_val));
    assign w_k = $signed(IW'(k_eff));
    assign num = IW'(prev_q) * (w_n - w_k) + IW'($signed(i_sram_data)) * w_k;
    assign quo = num / w_n;
    assign sample_val = (i_mode == 2'b11) ? DATA_W'(quo) : i_sram_data;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        k_d     = k_q;
        prev_d  = prev_q;
        fin_d   = 1'b0;
        dac_d   = '0;
        case (state_q)
            IDLE: begin
                if (!i_stop && !i_pause && i_start) begin
                    state_d = PLAY;
                    addr_d  = i_reverse ? i_stop_addr : i_start_addr;
                    k_d     = '0;
                    prev_d  = '0;
                end
            end
            PLAY: begin
                if (i_stop) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    k_d     = '0;
                    prev_d  = '0;
                    fin_d   = 1'b1;
                end else if (i_pause) begin
                    state_d = PAUSE;
                end else begin
                    dac_d = sample_val;
                    k_d   = k_eff;
                    if (tick) begin
                        if (!do_step) begin
                            k_d = k_inc[SPEED_W-1:0];
                        end else if (out_of_win) begin
                            state_d = IDLE;
                            addr_d  = '0;
                            k_d     = '0;
                            prev_d  = '0;
                            fin_d   = 1'b1;
                            dac_d   = '0;
                        end else begin
                            addr_d = nxt_addr;
                            k_d    = '0;
                            if (i_mode == 2'b11)
                                prev_d = $signed(i_sram_data);
                        end
                    end
                end
            end
            PAUSE: begin
                if (i_stop) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    k_d     = '0;
                    prev_d  = '0;
                    fin_d   = 1'b1;
                end else if (!i_pause && i_start) begin
                    state_d = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            k_q     <= '0;
            prev_q  <= '0;
            dac_q   <= '0;
            fin_q   <= 1'b0;
            lrck_q  <= 1'b0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            prev_q  <= prev_d;
            dac_q   <= dac_d;
            fin_q   <= fin_d;
            lrck_q  <= i_daclrck;
            mode_q  <= i_mode;
        end
    end

    assign o_dac_data  = dac_q;
    assign o_sram_addr = addr_q;
    assign o_fin       = fin_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_aud_dsp_player.sv
// Self-checking bench for aud_dsp_player: directed scenarios plus randomized
// playbacks compared against a tick-level reference model.
module tb_aud_dsp_player;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_start = 1'b0;
    logic               i_pause = 1'b0;
    logic               i_stop = 1'b0;
    logic [1:0]         i_mode = 2'b00;
    logic               i_reverse = 1'b0;
    logic [2:0]         i_speed = 3'd0;
    logic               i_daclrck = 1'b0;
    logic [15:0]        i_sram_data;
    logic [19:0]        i_start_addr = '0;
    logic [19:0]        i_stop_addr = '0;
    logic signed [15:0] o_dac_data;
    logic [19:0]        o_sram_addr;
    logic               o_fin;
    logic [1:0]         o_state;

    aud_dsp_player #(.DATA_W(16), .ADDR_W(20), .SPEED_W(3)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_pause(i_pause),
        .i_stop(i_stop), .i_mode(i_mode), .i_reverse(i_reverse), .i_speed(i_speed),
        .i_daclrck(i_daclrck), .i_sram_data(i_sram_data),
        .i_start_addr(i_start_addr), .i_stop_addr(i_stop_addr),
        .o_dac_data(o_dac_data), .o_sram_addr(o_sram_addr), .o_fin(o_fin),
        .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    logic signed [15:0] mem [0:255];
    assign i_sram_data = mem[o_sram_addr[7:0]];

    int fin_cnt = 0;
    always @(negedge i_clk) if (o_fin === 1'b1) fin_cnt++;

    int tests = 0;
    int failed = 0;

    // Reference model: playback position expressed as plain integers
    int m_addr, m_k, m_prev, m_n, m_mode, m_rev, m_ws, m_we;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_dac();
        if (m_mode == 3)
            return (m_prev * (m_n - m_k) + int'(mem[m_addr[7:0]]) * m_k) / m_n;
        return int'(mem[m_addr[7:0]]);
    endfunction

    task automatic model_tick(output bit ended);
        int step, nxt;
        ended = 1'b0;
        if (m_mode >= 2) begin
            m_k++;
            if (m_k < m_n) return;
            m_k = 0;
        end
        step = (m_mode == 1) ? m_n : 1;
        nxt  = m_rev ? m_addr - step : m_addr + step;
        if (nxt < m_ws || nxt > m_we) begin
            ended  = 1'b1;
            m_addr = 0;
            m_k    = 0;
            m_prev = 0;
        end else begin
            if (m_mode == 3) m_prev = int'(mem[m_addr[7:0]]);
            m_addr = nxt;
        end
    endtask

    task automatic tick_once();
        @(negedge i_clk) i_daclrck = 1'b1;
        repeat (2) @(negedge i_clk);
        i_daclrck = 1'b0;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic setup(input int mode, input int speed, input int rev, input int ws, input int we);
        i_mode = 2'(mode); i_speed = 3'(speed); i_reverse = rev[0];
        i_start_addr = 20'(ws); i_stop_addr = 20'(we);
        m_mode = mode; m_n = speed + 1; m_rev = rev; m_ws = ws; m_we = we;
        m_addr = rev ? we : ws; m_k = 0; m_prev = 0;
    endtask

    task automatic start_play();
        @(negedge i_clk) i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic stop_play();
        @(negedge i_clk) i_stop = 1'b1;
        @(negedge i_clk) i_stop = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic check_play(input string tag);
        chk({tag, ".state"}, int'(o_state), 1);
        chk({tag, ".addr"}, int'(o_sram_addr), m_addr);
        chk({tag, ".dac"}, int'(o_dac_data), exp_dac());
    endtask

    task automatic step_checked(input string tag, output bit ended);
        int f0;
        f0 = fin_cnt;
        tick_once();
        model_tick(ended);
        if (ended) begin
            chk({tag, ".fin"}, fin_cnt - f0, 1);
            chk({tag, ".end_state"}, int'(o_state), 0);
            chk({tag, ".end_addr"}, int'(o_sram_addr), 0);
            chk({tag, ".end_dac"}, int'(o_dac_data), 0);
        end else begin
            chk({tag, ".nofin"}, fin_cnt - f0, 0);
            check_play(tag);
        end
    endtask

    task automatic run_play(input string tag, input int mode, input int speed, input int rev,
                            input int ws, input int we, input int maxt);
        bit ended;
        setup(mode, speed, rev, ws, we);
        start_play();
        check_play({tag, ".start"});
        ended = 1'b0;
        for (int t = 0; t < maxt && !ended; t++) step_checked(tag, ended);
        tests++;
        assert (ended) else begin
            failed++;
            $error("FAIL %s.timeout: observed running expected ended after %0d ticks", tag, maxt);
        end
    endtask

    int exp3 [0:11] = '{0, 100, 200, 300, 400, 200, 0, -200, -400, -200, 0, 200};

    initial begin
        bit ended;
        int f0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

        repeat (3) @(negedge i_clk);
        chk("rst.state", int'(o_state), 0);
        chk("rst.addr", int'(o_sram_addr), 0);
        chk("rst.dac", int'(o_dac_data), 0);
        chk("rst.fin", int'(o_fin), 0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        run_play("t1_normal", 0, 0, 0, 10, 13, 6);
        run_play("t2_fast", 1, 2, 0, 0, 20, 10);
        run_play("t4_rev", 0, 0, 1, 5, 7, 5);
        run_play("t4_rev0", 0, 0, 1, 0, 2, 5);
        run_play("fast_rev0", 1, 4, 1, 0, 13, 10);
        run_play("slowhold", 2, 2, 0, 40, 43, 20);

        // Slow-linear interpolation across 0 -> 400 -> -400 -> 400
        mem[100] = 16'sd400; mem[101] = -16'sd400; mem[102] = 16'sd400;
        setup(3, 3, 0, 100, 102);
        start_play();
        chk("t3.dac0", int'(o_dac_data), exp3[0]);
        for (int i = 1; i < 12; i++) begin
            tick_once();
            chk($sformatf("t3.dac%0d", i), int'(o_dac_data), exp3[i]);
        end
        f0 = fin_cnt;
        tick_once();
        chk("t3.fin", fin_cnt - f0, 1);
        chk("t3.state", int'(o_state), 0);

        // Pause with a partially elapsed slow-hold phase
        setup(2, 3, 0, 8, 20);
        start_play();
        check_play("t5.start");
        for (int i = 0; i < 2; i++) step_checked("t5.pre", ended);
        @(negedge i_clk) i_pause = 1'b1;
        @(negedge i_clk) i_pause = 1'b0;
        @(negedge i_clk);
        chk("t5.pstate", int'(o_state), 2);
        chk("t5.pdac", int'(o_dac_data), 0);
        f0 = fin_cnt;
        for (int i = 0; i < 50; i++) tick_once();
        chk("t5.hold_addr", int'(o_sram_addr), 8);
        chk("t5.hold_state", int'(o_state), 2);
        chk("t5.hold_dac", int'(o_dac_data), 0);
        chk("t5.hold_fin", fin_cnt - f0, 0);
        start_play();
        check_play("t5.resume");
        for (int i = 0; i < 2; i++) step_checked("t5.post", ended);
        chk("t5.stepped", int'(o_sram_addr), 9);
        stop_play();

        // Simultaneous stop/pause/start: stop wins
        setup(0, 0, 0, 30, 60);
        start_play();
        for (int i = 0; i < 2; i++) step_checked("t6.pre", ended);
        f0 = fin_cnt;
        @(negedge i_clk) begin i_stop = 1'b1; i_pause = 1'b1; i_start = 1'b1; end
        @(negedge i_clk) begin i_stop = 1'b0; i_pause = 1'b0; i_start = 1'b0; end
        @(negedge i_clk);
        chk("t6.fin", fin_cnt - f0, 1);
        chk("t6.state", int'(o_state), 0);
        chk("t6.addr", int'(o_sram_addr), 0);

        // Asynchronous reset mid-play
        setup(0, 0, 0, 30, 60);
        start_play();
        step_checked("t6.rst_pre", ended);
        f0 = fin_cnt;
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("t6.rst_state", int'(o_state), 0);
        chk("t6.rst_addr", int'(o_sram_addr), 0);
        chk("t6.rst_dac", int'(o_dac_data), 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("t6.rst_nofin", fin_cnt - f0, 0);

        for (int r = 0; r < 8; r++) begin
            int ws;
            ws = int'($urandom_range(0, 200));
            run_play($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1)), ws, ws + int'($urandom_range(0, 24)), 400);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
